// File: rtl/hidden_layer_sched.sv
// hidden_layer_sched: issues NUM_NEURONS logical neurons to one shared
// hidden_neuron datapath, one per cycle. It also captures each result and
// tracks the running argmax.
module hidden_layer_sched #(
  parameter int NUM_NEURONS = 4,
  parameter int AW          = $clog2(4 * NUM_NEURONS),
  parameter int NW          = $clog2(NUM_NEURONS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [3:0]    x_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [NW-1:0] rd_addr_i,
  output logic [9:0]    rd_data_o,
  output logic          nrn_en_o,
  output logic [3:0]    nrn_x_o,
  output logic [7:0]    nrn_w0_o,
  output logic [7:0]    nrn_w1_o,
  output logic [7:0]    nrn_w2_o,
  output logic [7:0]    nrn_w3_o,
  input  logic [9:0]    nrn_result_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [NW-1:0] argmax_o,
  output logic [9:0]    max_o
);

  localparam int unsigned NUM_N = NUM_NEURONS;
  localparam int unsigned NUM_W = 4 * NUM_NEURONS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   issue_idx_q, issue_idx_d;
  logic [3:0]      x_q, x_d;
  logic            done_q, done_d;
  logic            cap_valid_q, cap_valid_d;
  logic [NW-1:0]   cap_idx_q, cap_idx_d;
  logic [9:0]      max_q, max_d;
  logic [NW-1:0]   argmax_q, argmax_d;
  logic [7:0]      bank_q [NUM_W];
  logic [7:0]      bank_d [NUM_W];
  logic [9:0]      res_q  [NUM_NEURONS];
  logic [9:0]      res_d  [NUM_NEURONS];
  logic            start_acc;

  assign start_acc = (state_q == S_IDLE) && start_i;

  // Sequencer: next state, issue index, and datapath drive for the issued neuron.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    x_d         = x_q;
    done_d      = 1'b0;
    nrn_en_o    = 1'b0;
    nrn_w0_o    = '0;
    nrn_w1_o    = '0;
    nrn_w2_o    = '0;
    nrn_w3_o    = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_RUN;
          x_d         = x_i;
          issue_idx_d = '0;
        end
      end
      S_RUN: begin
        nrn_en_o    = 1'b1;
        nrn_w0_o    = bank_q[{issue_idx_q, 2'd0}];
        nrn_w1_o    = bank_q[{issue_idx_q, 2'd1}];
        nrn_w2_o    = bank_q[{issue_idx_q, 2'd2}];
        nrn_w3_o    = bank_q[{issue_idx_q, 2'd3}];
        issue_idx_d = issue_idx_q + NW'(1);
        if (issue_idx_q == NW'(NUM_NEURONS - 1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture stage: store the registered datapath result; track max with strict > so ties keep the lower index.
  always_comb begin
    cap_valid_d = nrn_en_o;
    cap_idx_d   = issue_idx_q;
    res_d       = res_q;
    max_d       = max_q;
    argmax_d    = argmax_q;
    if (start_acc) begin
      max_d    = '0;
      argmax_d = '0;
    end else if (cap_valid_q) begin
      res_d[cap_idx_q] = nrn_result_i;
      if (nrn_result_i > max_q) begin
        max_d    = nrn_result_i;
        argmax_d = cap_idx_q;
      end
    end
  end

  // Weight bank: host writes land only while idle and in range; others vanish.
  always_comb begin
    bank_d = bank_q;
    if (wr_en_i && (state_q == S_IDLE) && (32'(wr_addr_i) < NUM_W)) begin
      bank_d[wr_addr_i] = wr_data_i;
    end
  end

  // Result readback, zero for indices beyond the neuron count.
  always_comb begin
    rd_data_o = '0;
    if (32'(rd_addr_i) < NUM_N) rd_data_o = res_q[rd_addr_i];
  end

  // State registers; reset aborts any pass and clears both banks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      issue_idx_q <= '0;
      x_q         <= '0;
      done_q      <= 1'b0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      max_q       <= '0;
      argmax_q    <= '0;
      // NOTE: the banks are flop arrays that must read back zero after reset, so they are reset explicitly here.
      for (int i = 0; i < NUM_W; i++) bank_q[i] <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) res_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      x_q         <= x_d;
      done_q      <= done_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      max_q       <= max_d;
      argmax_q    <= argmax_d;
      bank_q      <= bank_d;
      res_q       <= res_d;
    end
  end

  assign nrn_x_o  = x_q;
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign max_o    = max_q;
  assign argmax_o = argmax_q;

endmodule

// File: tb/tb_hidden_layer_sched.sv
// tb_hidden_layer_sched: directed and randomized passes against an
// array-based reference of the layer. A stand-in neuron sums the weights
// selected by x.
module tb_hidden_layer_sched;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  // Main instance, N = 4
  logic       start_i, wr_en_i, nrn_en, busy, done;
  logic [3:0] x_i, wr_addr_i, nrn_x;
  logic [7:0] wr_data_i, w0, w1, w2, w3;
  logic [1:0] rd_addr_i, argmax;
  logic [9:0] rd_data, nres, max_v;

  hidden_layer_sched #(.NUM_NEURONS(N)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .x_i(x_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data),
    .nrn_en_o(nrn_en), .nrn_x_o(nrn_x),
    .nrn_w0_o(w0), .nrn_w1_o(w1), .nrn_w2_o(w2), .nrn_w3_o(w3),
    .nrn_result_i(nres), .busy_o(busy), .done_o(done),
    .argmax_o(argmax), .max_o(max_v)
  );

  // Second instance, N = 3, so that out-of-range addresses exist
  logic       start3, wr_en3, nrn_en3, busy3, done3;
  logic [3:0] x3, wr_addr3, nrn_x3;
  logic [7:0] wr_data3, v0, v1, v2, v3;
  logic [1:0] rd_addr3, argmax3;
  logic [9:0] rd_data3, nres3, max3;

  hidden_layer_sched #(.NUM_NEURONS(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .start_i(start3), .x_i(x3),
    .wr_en_i(wr_en3), .wr_addr_i(wr_addr3), .wr_data_i(wr_data3),
    .rd_addr_i(rd_addr3), .rd_data_o(rd_data3),
    .nrn_en_o(nrn_en3), .nrn_x_o(nrn_x3),
    .nrn_w0_o(v0), .nrn_w1_o(v1), .nrn_w2_o(v2), .nrn_w3_o(v3),
    .nrn_result_i(nres3), .busy_o(busy3), .done_o(done3),
    .argmax_o(argmax3), .max_o(max3)
  );

  function automatic logic [9:0] nsum(logic [3:0] x, logic [7:0] a, logic [7:0] b,
                                      logic [7:0] c, logic [7:0] d);
    return (x[0] ? 10'(a) : 10'd0) + (x[1] ? 10'(b) : 10'd0) +
           (x[2] ? 10'(c) : 10'd0) + (x[3] ? 10'(d) : 10'd0);
  endfunction

  // Stand-in hidden_neuron datapaths: one registered stage each.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      nres  <= '0;
      nres3 <= '0;
    end else begin
      if (nrn_en)  nres  <= nsum(nrn_x, w0, w1, w2, w3);
      if (nrn_en3) nres3 <= nsum(nrn_x3, v0, v1, v2, v3);
    end
  end

  int         tests = 0;
  int         fails = 0;
  logic [7:0] wm [4*N];
  logic [9:0] exp_res [N];
  logic [9:0] exp_max;
  int         exp_arg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int a = 0; a < 4*N; a++) wm[a] = 8'h00;
  endtask

  task automatic write_w(input int addr, input logic [7:0] data);
    wr_en_i   = 1'b1;
    wr_addr_i = 4'(addr);
    wr_data_i = data;
    @(posedge clk); #1;
    wr_en_i   = 1'b0;
    wm[addr]  = data;
  endtask

  task automatic compute_expected(input logic [3:0] x);
    int s;
    exp_max = '0;
    exp_arg = 0;
    for (int k = 0; k < N; k++) begin
      s = 0;
      for (int j = 0; j < 4; j++) if (x[j]) s += int'(wm[k*4 + j]);
      exp_res[k] = 10'(s);
      if (exp_res[k] > exp_max) begin
        exp_max = exp_res[k];
        exp_arg = k;
      end
    end
  endtask

  // One full pass. The caller is #1 after an edge; returns #1 after the edge ending the done cycle's predecessor.
  task automatic run_pass(input logic [3:0] x, input bit hold, input bit midwrite, input string tag);
    compute_expected(x);
    x_i     = x;
    start_i = 1'b1;
    @(posedge clk); #1;
    if (!hold) start_i = 1'b0;
    for (int j = 0; j <= N; j++) begin
      if (midwrite && j == 1) begin
        wr_en_i = 1'b1; wr_addr_i = 4'd5; wr_data_i = 8'hEE;
      end else begin
        wr_en_i = 1'b0;
      end
      check({tag, " en"},   32'(nrn_en), 32'(j < N));
      check({tag, " busy"}, 32'(busy),   32'd1);
      check({tag, " done"}, 32'(done),   32'd0);
      check({tag, " x"},    32'(nrn_x),  32'(x));
      if (j < N) begin
        check({tag, " w0"}, 32'(w0), 32'(wm[j*4 + 0]));
        check({tag, " w1"}, 32'(w1), 32'(wm[j*4 + 1]));
        check({tag, " w2"}, 32'(w2), 32'(wm[j*4 + 2]));
        check({tag, " w3"}, 32'(w3), 32'(wm[j*4 + 3]));
      end else begin
        check({tag, " w0 idle"}, 32'(w0), 32'd0);
      end
      @(posedge clk); #1;
    end
    wr_en_i = 1'b0;
    check({tag, " done pulse"}, 32'(done),   32'd1);
    check({tag, " busy end"},   32'(busy),   32'd0);
    check({tag, " en end"},     32'(nrn_en), 32'd0);
    check({tag, " max"},        32'(max_v),  32'(exp_max));
    check({tag, " argmax"},     32'(argmax), 32'(exp_arg));
    for (int k = 0; k < N; k++) begin
      rd_addr_i = 2'(k);
      #1;
      check({tag, " result"}, 32'(rd_data), 32'(exp_res[k]));
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start_i = 1'b0; x_i = '0; wr_en_i = 1'b0; wr_addr_i = '0;
    wr_data_i = '0; rd_addr_i = '0;
    start3 = 1'b0; x3 = '0; wr_en3 = 1'b0; wr_addr3 = '0; wr_data3 = '0; rd_addr3 = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset and idle
    repeat (5) begin
      @(posedge clk); #1;
      check("idle en",     32'(nrn_en),  32'd0);
      check("idle busy",   32'(busy),    32'd0);
      check("idle done",   32'(done),    32'd0);
      check("idle max",    32'(max_v),   32'd0);
      check("idle argmax", 32'(argmax),  32'd0);
      check("idle w0",     32'(w0),      32'd0);
      check("idle x",      32'(nrn_x),   32'd0);
      check("idle rd",     32'(rd_data), 32'd0);
    end

    // Single pass, uniform weights
    for (int a = 0; a < 4*N; a++) write_w(a, 8'h40);
    run_pass(4'b1111, 1'b0, 1'b0, "uniform");
    check("uniform max abs", 32'(max_v), 32'h100);

    // Distinct sums
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 4; j++) write_w(k*4 + j, 8'(8'h10 * (k + 1)));
    run_pass(4'b0101, 1'b0, 1'b0, "distinct");
    check("distinct argmax abs", 32'(argmax), 32'd3);
    check("distinct max abs",    32'(max_v),  32'h80);

    // Tie with a mid-pass write that must be dropped
    for (int j = 0; j < 4; j++) begin
      write_w(0*4 + j, 8'h10);
      write_w(1*4 + j, 8'h30);
      write_w(2*4 + j, 8'h30);
      write_w(3*4 + j, 8'h20);
    end
    run_pass(4'b1111, 1'b0, 1'b1, "tie");
    check("tie argmax abs", 32'(argmax), 32'd1);
    run_pass(4'b1111, 1'b0, 1'b0, "after_block");

    // Start held across done: back-to-back passes with period N+2
    run_pass(4'b0011, 1'b1, 1'b0, "b2b_a");
    run_pass(4'b1100, 1'b0, 1'b0, "b2b_b");

    // Abort mid-RUN
    x_i = 4'b1111; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    clear_model();
    check("abort en",     32'(nrn_en),  32'd0);
    check("abort busy",   32'(busy),    32'd0);
    check("abort done",   32'(done),    32'd0);
    check("abort x",      32'(nrn_x),   32'd0);
    check("abort max",    32'(max_v),   32'd0);
    check("abort w1",     32'(w1),      32'd0);
    check("abort rd",     32'(rd_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (N + 3) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("abort no done", 32'(seen), 32'd0);

    // Randomized passes after reset
    repeat (4) begin
      for (int a = 0; a < 4*N; a++) write_w(a, 8'($urandom));
      run_pass(4'($urandom), 1'b0, 1'b0, "random");
    end

    // Out-of-range writes on the three-neuron instance
    for (int a = 0; a < 16; a++) begin
      wr_en3 = 1'b1; wr_addr3 = 4'(a); wr_data3 = (a < 12) ? 8'h01 : 8'hFF;
      @(posedge clk); #1;
    end
    wr_en3 = 1'b0;
    x3 = 4'b1111; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (done3) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("n3 done seen", 32'(seen),    32'd1);
    check("n3 max",       32'(max3),    32'd4);
    check("n3 argmax",    32'(argmax3), 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd_addr3 = 2'(k);
      #1;
      check("n3 result", 32'(rd_data3), (k < 3) ? 32'd4 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hidden_layer_sched.md
# hidden_layer_sched

Sequencer that time-multiplexes one `hidden_neuron` datapath across `NUM_NEURONS` logical hidden neurons. It holds a local weight bank, latches the 4-bit input vector on `start_i`, and issues one neuron per cycle to the datapath with `en_i` and the matching `w0_i..w3_i`. It captures each registered result into a result bank and tracks the running argmax. It sits between the host/config interface and the single shared neuron instance, and feeds the output layer.

## Interface
Parameters:
- `NUM_NEURONS`, default 4: logical hidden neurons, legal range 2..16.
- `AW`, default `$clog2(4*NUM_NEURONS)`: weight address width.
- `NW`, default `$clog2(NUM_NEURONS)`: neuron index width.

Ports:
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: begin a layer pass; sampled only in IDLE.
- `x_i` in 4: input vector, latched on accepted start.
- `wr_en_i` in 1: weight write strobe.
- `wr_addr_i` in AW: weight address, neuron*4 + weight index (0..3).
- `wr_data_i` in 8: weight value (1.7 unsigned).
- `rd_addr_i` in NW: result read index.
- `rd_data_o` out 10: combinational result[rd_addr_i]; 0 if out of range.
- `nrn_en_o` out 1: to datapath `en_i`.
- `nrn_x_o` out 4: to datapath `x_i`, latched vector.
- `nrn_w0_o`..`nrn_w3_o` out 8 each: to datapath weights for the issued neuron.
- `nrn_result_i` in 10: from datapath `hidden_neuron_o`.
- `busy_o` out 1: pass in progress.
- `done_o` out 1: one-cycle pulse, pass complete.
- `argmax_o` out NW: index of the largest captured result in the last pass.
- `max_o` out 10: value at `argmax_o`.

## Operation
- The FSM has three states: IDLE, RUN, DRAIN.
- IDLE → RUN when `start_i`=1. On that edge: `x_q`<=`x_i`, `issue_idx`<=0, `max_o`<=0, `argmax_o`<=0.
- RUN:
  - `nrn_en_o`=1.
  - `nrn_w*_o` = bank[issue_idx*4 + 0..3].
  - `issue_idx` increments each cycle.
  - After issuing index N-1, go to DRAIN.
- DRAIN: `nrn_en_o`=0 for one cycle while the final capture completes, then go to IDLE and pulse `done_o`.
- Capture pipeline:
  - `cap_valid`/`cap_idx` are `nrn_en_o`/`issue_idx` delayed one cycle.
  - When `cap_valid`=1: result[cap_idx]<=`nrn_result_i`.
  - If `nrn_result_i` > `max_o`, update `max_o`/`argmax_o`.
  - Ties keep the lower index, using strict greater-than.
- Outside RUN: `nrn_en_o`=0 and `nrn_w*_o`=0. `nrn_x_o` always shows `x_q`.
- Weight writes:
  - Accepted only when `busy_o`=0.
  - Writes with `busy_o`=1 are dropped silently.
  - Writes with `wr_addr_i` ≥ 4*NUM_NEURONS are ignored.
- `start_i` while busy is ignored. There is no queueing.
- Arithmetic: only compares, unsigned 10-bit. Results are stored unmodified; there is no saturation.

## Timing
- Reset value of every output is 0, and all banks, `x_q`, the FSM (IDLE), and counters clear.
- Reset mid-pass aborts immediately. `done_o` never fires for the aborted pass.
- Edge E0 samples `start_i`.
- Neuron k is issued in the cycle after E(k) and captured at edge E(k+2).
- The last capture is at E(N+1). `done_o`=1 in the cycle after E(N+1).
- `busy_o`=1 from after E0 through the cycle ending at E(N+1).
- Start-to-done latency is N+1 cycles.
- A new `start_i` is accepted in the same cycle `done_o` is high (state is IDLE). Back-to-back pass period is N+2 cycles.
- `rd_data_o` for index k reflects the new value from the cycle after E(k+2).

## Test plan
- **Reset and idle:** reset, then idle 5 cycles → all outputs 0; `nrn_en_o` never asserted.
- **Single pass, N=4:**
  - Stimulus: all weights 0x40; x=4'b1111; start.
  - `nrn_en_o` high exactly 4 cycles.
  - With a behavioural neuron model, results=0x100 each.
  - `done_o` at E5; argmax=0; max=0x100.
- **Distinct sums:** neuron k weights = 0x10*(k+1), x=4'b0101.
  - Results 0x20, 0x40, 0x60, 0x80.
  - argmax=3, max=0x80.
  - The `nrn_w*_o` sequence matches the bank order.
- **Tie and write blocking:**
  - Neurons 1 and 2 have equal top result → argmax=1.
  - A write issued mid-pass leaves the bank unchanged on readback in the next pass.
  - Out-of-range `wr_addr_i` is ignored.
- **Restart and abort:**
  - `start_i` held high across `done_o` → second pass begins the cycle after `done_o`, period N+2.
  - `rst_i` asserted mid-RUN → outputs 0 at once, no `done_o`; a fresh pass after reset completes normally.
